// File: rtl/drum_pkg.sv
// Shared definitions for the drum machine blocks: system mode encoding
// (matches the mode controller) and default array dimensions.
package drum_pkg;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        PLAY = 2'd1,
        RAW  = 2'd2
    } sysmode_t;

    localparam int DEF_NUM_TRACKS = 4;
    localparam int DEF_NUM_STEPS  = 16;
    localparam int DEF_PERIOD_W   = 24;

endpackage

// File: rtl/step_timer.sv
// Step timer: free-running counter that emits a one-cycle tick every
// max(period,1) clocks while run is high; restart or !run clears it.
module step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] last;

    // Period 0 behaves as 1; a shrinking period lets count wrap through overflow.
    assign last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick = run && !restart && (count == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || restart || tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern sequencer: edits a track x step pattern in EDIT, plays it back as
// trigger pulses in PLAY, and always forwards live pad strobes to trig.
module step_sequencer
    import drum_pkg::*;
#(
    parameter int NUM_TRACKS = DEF_NUM_TRACKS,
    parameter int NUM_STEPS  = DEF_NUM_STEPS,
    parameter int PERIOD_W   = DEF_PERIOD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [PERIOD_W-1:0]           step_period,
    input  logic                          cursor_left,
    input  logic                          cursor_right,
    input  logic                          edit_toggle,
    input  logic [$clog2(NUM_TRACKS)-1:0] edit_track,
    input  logic [NUM_TRACKS-1:0]         pad,
    output logic [NUM_TRACKS-1:0]         trig,
    output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
    output logic [$clog2(NUM_STEPS)-1:0]  cursor,
    output logic                          beat
);

    localparam int SW = $clog2(NUM_STEPS);

    logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern;
    logic [1:0]                           prev_mode;
    logic                                 is_play;
    logic                                 is_edit;
    logic                                 start;
    logic                                 tick;
    logic [SW-1:0]                        next_step;
    logic [SW-1:0]                        read_step;
    logic [NUM_TRACKS-1:0]                column;

    assign is_play   = (mode == PLAY);
    assign is_edit   = (mode == EDIT) || (mode == 2'd3);
    assign start     = is_play && (prev_mode != PLAY);
    assign next_step = step_idx + SW'(1);
    assign read_step = start ? '0 : next_step;

    always_comb begin
        column = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            column[t] = pattern[t][read_step];
        end
    end

    step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (is_play),
        .restart (start),
        .period  (step_period),
        .tick    (tick)
    );

    // Play path: pads are merged into every trigger, pattern hits only on step edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mode <= EDIT;
            trig      <= '0;
            beat      <= 1'b0;
            step_idx  <= '0;
        end else begin
            prev_mode <= mode;
            trig      <= pad;
            beat      <= 1'b0;
            if (start) begin
                step_idx <= '0;
                trig     <= column | pad;
                beat     <= 1'b1;
            end else if (is_play && tick) begin
                step_idx <= next_step;
                trig     <= column | pad;
                beat     <= (next_step == '0);
            end
        end
    end

    // Edit path: toggle uses the cursor value from before this cycle's move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            cursor  <= '0;
        end else if (is_edit) begin
            if (edit_toggle && (int'(edit_track) < NUM_TRACKS)) begin
                pattern[edit_track][cursor] <= ~pattern[edit_track][cursor];
            end
            if (cursor_right && !cursor_left) begin
                cursor <= cursor + SW'(1);
            end else if (cursor_left && !cursor_right) begin
                cursor <= cursor - SW'(1);
            end
        end
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Pattern sequencer that sits directly downstream of the mode controller and consumes its 2-bit mode output.
- EDIT: a cursor walks the steps and toggles pattern bits.
- PLAY: a step timer walks the pattern and fires per-track trigger pulses to the voice generators.
- RAW: live pads only.
Pad strobes are forwarded to the triggers in every mode, so pads are always audible.

Parameters:
NUM_TRACKS, 4, number of voices and pattern rows
NUM_STEPS, 16, steps per pattern; power of two
PERIOD_W, 24, width of step_period

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
mode  input  2  0=EDIT, 1=PLAY, 2=RAW, 3 treated as EDIT
step_period  input  PERIOD_W  clocks per step; 0 treated as 1
cursor_left  input  1  one-cycle strobe, move cursor down
cursor_right  input  1  one-cycle strobe, move cursor up
edit_toggle  input  1  one-cycle strobe, flip pattern[edit_track][cursor]
edit_track  input  $clog2(NUM_TRACKS)  track addressed by edit_toggle
pad  input  NUM_TRACKS  one-cycle pad strobes
trig  output  NUM_TRACKS  registered one-cycle trigger pulses
step_idx  output  $clog2(NUM_STEPS)  current play step
cursor  output  $clog2(NUM_STEPS)  current edit cursor
beat  output  1  one-cycle pulse when step 0 fires in PLAY

Behaviour:
- Reset (async, immediate): pattern all 0; trig=0, beat=0, step_idx=0, cursor=0; timer count=0; prev_mode register=EDIT.
- All outputs are registered. Nothing is combinational from the inputs.
- Pattern storage:
  - NUM_TRACKS x NUM_STEPS flops.
  - Written only in EDIT or mode 3.
  - Read in PLAY.
- Play start:
  - Start condition: mode==PLAY and prev_mode!=PLAY.
  - On that edge: step_idx<=0, count<=0, trig<=pattern[*][0] | pad, beat<=1.
  - Net effect: the first trigger appears 1 cycle after mode switches to PLAY.
- Play running:
  - count increments each cycle.
  - When count==max(step_period,1)-1: count<=0, step_idx<=step_idx+1 (wraps NUM_STEPS-1 -> 0), trig<=pattern[*][new step] | pad, beat<=(new step==0).
  - All other cycles: trig<=pad, beat<=0.
  - Step spacing is exactly max(step_period,1) cycles.
  - A change to step_period takes effect at the next compare. If count already exceeds the new limit, count wraps through the PERIOD_W overflow. No special casing.
- Leaving PLAY: count<=0; step_idx holds its value. Re-entry always restarts at step 0.
- EDIT / mode 3:
  - cursor_right alone: cursor+1 with wrap.
  - cursor_left alone: cursor-1 with wrap.
  - Both strobes asserted together: no move.
  - edit_toggle flips pattern[edit_track][cursor] using the pre-move cursor in the same cycle.
  - edit_track >= NUM_TRACKS: toggle ignored.
- RAW: no pattern or cursor activity; trig<=pad.
- Strobes outside EDIT: cursor and toggle strobes are ignored in PLAY and RAW.
- Triggers are never stretched. A held pad input repeats every cycle, so debouncing is the upstream block's job.
- Reset mid-PLAY: immediate clear. After rst deasserts with mode==PLAY, the start condition fires, because prev_mode was reset to EDIT.

Decomposition:
- Shared package drum_pkg:
  - sysmode_t enum {EDIT=0, PLAY=1, RAW=2}, matching the mode controller.
  - Default NUM_TRACKS and NUM_STEPS constants.
- One sub-module, step_timer:
  - Counter with restart input and period input.
  - Outputs a one-cycle tick when count==max(period,1)-1.
  - Same async reset.

Test Plan:
1. Edit then play:
   - Stimulus: reset; EDIT; toggle track0 at cursor 0; cursor_right x4; toggle track0 at step 4; step_period=4; mode=PLAY.
   - Required: trig=4'b0001 and beat=1 one cycle after entry; trig=4'b0001 again 16 cycles later (step 4); silence at steps 1-3 and 5-15.
   - Required: beat repeats every 64 cycles.
2. Wrap and simultaneous strobes:
   - cursor_left from 0 -> cursor=15.
   - cursor_left+cursor_right together -> cursor unchanged.
   - toggle+right in the same cycle -> old cursor bit flipped, cursor advances.
3. Play restart and strobes outside EDIT:
   - Leave PLAY at step_idx=7 -> step_idx holds 7.
   - Re-enter PLAY -> step_idx=0 and step-0 triggers fire on the next cycle.
   - cursor_left, cursor_right and edit_toggle strobes during PLAY -> cursor and pattern unchanged.
4. RAW pads:
   - mode=RAW, pad=4'b1010 for one cycle -> trig=4'b1010 exactly one cycle later, then 0.
   - Pattern and cursor unchanged.
5. step_period edge values and pad merge:
   - step_period=0 -> step advances every cycle.
   - step_period=1 -> same as 0.
   - Pad pulse coinciding with a pattern trigger in PLAY -> OR of both, still a single pulse.
6. Async reset mid-play:
   - Assert rst between clock edges during PLAY -> trig, beat, step_idx and pattern all zero before the next edge.
   - Release rst with mode=PLAY -> restart at step 0 with empty pattern, so no triggers fire.
